// File: rtl/game_controller_multi.sv
// rtl/game_controller_multi.sv - multi-object game controller: draw priority mux, collision latches, lives/level FSM
module game_controller_multi #(
  parameter int                 NUM_OBJ        = 6,
  parameter int                 SEL_W          = $clog2(NUM_OBJ + 2),
  parameter int                 PLAYER_PRIO    = 3,
  parameter logic [NUM_OBJ-1:0] HAZARD_MASK    = 6'b000111,
  parameter logic [NUM_OBJ-1:0] GOAL_MASK      = 6'b001000,
  parameter int                 INIT_LIVES     = 3,
  parameter int                 RESPAWN_FRAMES = 30,
  parameter int                 MAX_LEVEL      = 7
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               start_of_frame,
  input  logic               start_game,
  input  logic [NUM_OBJ-1:0] obj_draw_req,
  input  logic               player_draw_req,
  output logic [SEL_W-1:0]   select_mux,
  output logic               win_pulse,
  output logic               lose_pulse,
  output logic [2:0]         lives,
  output logic [2:0]         level,
  output logic               playing,
  output logic               game_over,
  output logic               game_won
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_HIT  = 2'd2;
  localparam logic [1:0] ST_OVER = 2'd3;

  localparam int               CNT_W        = $clog2(RESPAWN_FRAMES + 1);
  localparam logic [CNT_W-1:0] RESPAWN_LOAD = CNT_W'(RESPAWN_FRAMES);
  localparam logic [2:0]       INIT_L       = 3'(INIT_LIVES);
  localparam logic [2:0]       MAX_L        = 3'(MAX_LEVEL);
  localparam logic [SEL_W-1:0] PLAYER_SEL   = SEL_W'(NUM_OBJ + 1);

  logic [1:0]       r_state;
  logic [2:0]       r_lives;
  logic [2:0]       r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_hit;
  logic             r_goal;
  logic             r_won;
  logic             r_win_p;
  logic             r_lose_p;

  logic [SEL_W-1:0] w_sel;
  logic             w_hazard_ov;
  logic             w_goal_ov;

  assign w_hazard_ov = player_draw_req & (|(obj_draw_req & HAZARD_MASK));
  assign w_goal_ov   = player_draw_req & (|(obj_draw_req & GOAL_MASK));

  // Priority select: apply lowest-priority candidates first so higher ones overwrite.
  always_comb begin
    w_sel = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (i >= PLAYER_PRIO && obj_draw_req[i]) w_sel = SEL_W'(i + 1);
    end
    if (player_draw_req) w_sel = PLAYER_SEL;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (i < PLAYER_PRIO && obj_draw_req[i]) w_sel = SEL_W'(i + 1);
    end
  end

  // Game state machine, collision latches and registered event pulses.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state  <= ST_IDLE;
      r_lives  <= 3'd0;
      r_level  <= 3'd1;
      r_cnt    <= '0;
      r_hit    <= 1'b0;
      r_goal   <= 1'b0;
      r_won    <= 1'b0;
      r_win_p  <= 1'b0;
      r_lose_p <= 1'b0;
    end else begin
      r_win_p  <= 1'b0;
      r_lose_p <= 1'b0;
      case (r_state)
        ST_IDLE, ST_OVER: begin
          r_hit  <= 1'b0;
          r_goal <= 1'b0;
          if (start_game) begin
            r_lives <= INIT_L;
            r_level <= 3'd1;
            r_won   <= 1'b0;
            r_state <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (start_of_frame) begin
            // Commit uses last frame's latches; they are emptied for the new frame.
            r_hit  <= 1'b0;
            r_goal <= 1'b0;
            if (r_hit) begin
              r_lose_p <= 1'b1;
              if (r_lives != 3'd0) r_lives <= r_lives - 3'd1;
              if (r_lives <= 3'd1) begin
                r_state <= ST_OVER;
                r_won   <= 1'b0;
              end else begin
                r_state <= ST_HIT;
                r_cnt   <= RESPAWN_LOAD;
              end
            end else if (r_goal) begin
              r_win_p <= 1'b1;
              if (r_level >= MAX_L) begin
                r_state <= ST_OVER;
                r_won   <= 1'b1;
              end else begin
                if (r_level != 3'd7) r_level <= r_level + 3'd1;
                r_state <= ST_HIT;
                r_cnt   <= RESPAWN_LOAD;
              end
            end
          end else begin
            if (w_hazard_ov) r_hit  <= 1'b1;
            if (w_goal_ov)   r_goal <= 1'b1;
          end
        end
        ST_HIT: begin
          r_hit  <= 1'b0;
          r_goal <= 1'b0;
          if (start_of_frame) begin
            if (r_cnt <= CNT_W'(1)) begin
              r_cnt   <= '0;
              r_state <= ST_PLAY;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign select_mux = w_sel;
  assign win_pulse  = r_win_p;
  assign lose_pulse = r_lose_p;
  assign lives      = r_lives;
  assign level      = r_level;
  assign playing    = (r_state == ST_PLAY);
  assign game_over  = (r_state == ST_OVER);
  assign game_won   = r_won;

endmodule

// File: tb/tb_game_controller_multi.sv
// tb/tb_game_controller_multi.sv - self-checking bench for game_controller_multi against a behavioural model
module tb_game_controller_multi;

  localparam int         NUM_OBJ     = 6;
  localparam int         SEL_W       = 3;
  localparam int         PLAYER_PRIO = 3;
  localparam logic [5:0] HMASK       = 6'b000111;
  localparam logic [5:0] GMASK       = 6'b001000;
  localparam int         INIT_LIVES  = 3;
  localparam int         RESPAWN     = 30;
  localparam int         MAX_LEVEL   = 7;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       sof = 1'b0;
  logic       sg = 1'b0;
  logic       pl = 1'b0;
  logic [5:0] obj = '0;

  logic [2:0] sel;
  logic       win_p, lose_p;
  logic [2:0] lives, level;
  logic       playing, game_over, game_won;

  int n_cmp = 0;
  int n_bad = 0;

  game_controller_multi #(
    .NUM_OBJ(NUM_OBJ), .SEL_W(SEL_W), .PLAYER_PRIO(PLAYER_PRIO),
    .HAZARD_MASK(HMASK), .GOAL_MASK(GMASK), .INIT_LIVES(INIT_LIVES),
    .RESPAWN_FRAMES(RESPAWN), .MAX_LEVEL(MAX_LEVEL)
  ) dut (
    .clk(clk), .resetN(resetN), .start_of_frame(sof), .start_game(sg),
    .obj_draw_req(obj), .player_draw_req(pl), .select_mux(sel),
    .win_pulse(win_p), .lose_pulse(lose_p), .lives(lives), .level(level),
    .playing(playing), .game_over(game_over), .game_won(game_won)
  );

  always #5 clk = ~clk;

  // Behavioural model: game phase plus counters held as plain integers.
  typedef enum {M_IDLE, M_PLAY, M_RESPAWN, M_OVER} mode_t;
  mode_t m_mode;
  int    m_lives, m_level, m_left;
  bit    m_haz, m_goal, m_won, m_winp, m_losep;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Walk the drawing ranks from the top: objects below PLAYER_PRIO, then the frog, then the rest.
  function automatic int exp_sel(input logic [5:0] o, input logic p);
    int who;
    for (int r = 0; r <= NUM_OBJ; r++) begin
      if (r < PLAYER_PRIO) who = r;
      else if (r == PLAYER_PRIO) who = -1;
      else who = r - 1;
      if (who < 0) begin
        if (p) return NUM_OBJ + 1;
      end else if (o[who]) begin
        return who + 1;
      end
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_lives = 0; m_level = 1; m_left = 0;
    m_haz = 0; m_goal = 0; m_won = 0; m_winp = 0; m_losep = 0;
  endtask

  task automatic model_step();
    if (!resetN) begin
      model_reset();
    end else begin
      m_winp = 0;
      m_losep = 0;
      case (m_mode)
        M_IDLE, M_OVER: begin
          m_haz = 0; m_goal = 0;
          if (sg) begin
            m_lives = INIT_LIVES; m_level = 1; m_won = 0; m_mode = M_PLAY;
          end
        end
        M_PLAY: begin
          if (sof) begin
            if (m_haz) begin
              m_losep = 1;
              m_lives = (m_lives > 0) ? m_lives - 1 : 0;
              if (m_lives == 0) begin
                m_mode = M_OVER; m_won = 0;
              end else begin
                m_mode = M_RESPAWN; m_left = RESPAWN;
              end
            end else if (m_goal) begin
              m_winp = 1;
              if (m_level == MAX_LEVEL) begin
                m_mode = M_OVER; m_won = 1;
              end else begin
                m_level = m_level + 1; m_mode = M_RESPAWN; m_left = RESPAWN;
              end
            end
            m_haz = 0; m_goal = 0;
          end else if (pl) begin
            if ((obj & HMASK) != 0) m_haz = 1;
            if ((obj & GMASK) != 0) m_goal = 1;
          end
        end
        M_RESPAWN: begin
          if (sof) begin
            m_left = m_left - 1;
            if (m_left == 0) m_mode = M_PLAY;
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  task automatic check_regs();
    check("win_pulse", win_p, m_winp);
    check("lose_pulse", lose_p, m_losep);
    check("lives", lives, m_lives);
    check("level", level, m_level);
    check("playing", playing, (m_mode == M_PLAY));
    check("game_over", game_over, (m_mode == M_OVER));
    check("game_won", game_won, m_won);
    check("pulse_exclusive", win_p & lose_p, 0);
  endtask

  // One clock: drive after the falling edge, check select, step model at the rising edge, check registers.
  task automatic cycle(input bit s, input bit g, input logic [5:0] o, input bit p);
    sof = s; sg = g; obj = o; pl = p;
    #1;
    check("select_mux", sel, exp_sel(o, p));
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_regs();
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 6'b0, 0);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1, 0, 6'b0, 0);
      quiet(2);
    end
  endtask

  // Overlap the frog with the given objects for 5 pixels, then close the frame.
  task automatic overlap_frame(input logic [5:0] o);
    quiet(2);
    for (int i = 0; i < 5; i++) cycle(0, 0, o, 1);
    quiet(2);
    cycle(1, 0, 6'b0, 0);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    check_regs();
    check("reset_lives", lives, 0);
    check("reset_level", level, 1);
    quiet(2);
    resetN = 1'b1;
    quiet(2);

    // Draw priority
    cycle(0, 0, 6'b101000, 1); check("prio_player_over_3_5", sel, 7);
    cycle(0, 0, 6'b000100, 1); check("prio_obj2_over_player", sel, 3);
    cycle(0, 0, 6'b000000, 0); check("prio_none", sel, 0);

    // Hazard and respawn
    cycle(0, 1, 6'b0, 0);
    check("start_playing", playing, 1);
    check("start_lives", lives, 3);
    overlap_frame(6'b000001);
    check("hazard_lose_pulse", lose_p, 1);
    check("hazard_lives", lives, 2);
    check("hazard_not_playing", playing, 0);
    quiet(1);
    check("lose_pulse_one_cycle", lose_p, 0);
    frames(RESPAWN - 1);
    check("respawn_still_hit", playing, 0);
    frames(1);
    check("respawn_done", playing, 1);

    // Game over
    overlap_frame(6'b000010);
    frames(RESPAWN);
    overlap_frame(6'b000100);
    check("over_lives", lives, 0);
    check("over_flag", game_over, 1);
    check("over_not_won", game_won, 0);
    overlap_frame(6'b000001);
    check("over_no_pulse", lose_p, 0);
    cycle(0, 1, 6'b0, 0);
    check("restart_lives", lives, 3);
    check("restart_level", level, 1);
    check("restart_playing", playing, 1);

    // Goals and levels
    for (int k = 2; k <= MAX_LEVEL; k++) begin
      overlap_frame(6'b001000);
      check("goal_win_pulse", win_p, 1);
      check("goal_level", level, k);
      frames(RESPAWN);
    end
    overlap_frame(6'b001000);
    check("final_win_pulse", win_p, 1);
    check("final_won", game_won, 1);
    check("final_over", game_over, 1);
    check("final_level", level, 7);

    // Hazard and goal in one frame
    cycle(0, 1, 6'b0, 0);
    check("restart_clears_won", game_won, 0);
    overlap_frame(6'b001100);
    check("both_lose", lose_p, 1);
    check("both_no_win", win_p, 0);
    check("both_level", level, 1);
    check("both_lives", lives, 2);

    // Reset in HIT with 12 frames remaining
    frames(RESPAWN - 12);
    resetN = 1'b0;
    #1;
    model_reset();
    check("async_reset_lives", lives, 0);
    check("async_reset_level", level, 1);
    check("async_reset_playing", playing, 0);
    check("async_reset_pulses", win_p | lose_p, 0);
    quiet(1);
    resetN = 1'b1;
    cycle(0, 1, 6'b0, 0);
    check("post_reset_playing", playing, 1);
    check("post_reset_lives", lives, 3);

    // Randomized play
    for (int i = 0; i < 15000; i++) begin
      cycle(($urandom_range(0, 9) == 0), ($urandom_range(0, 199) == 0),
            6'($urandom & $urandom), $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
